double_to_fixed: RTL
====================

DOUBLE_TO_FIXED -- requirements
Module: double_to_fixed

Interface
REQ-001 Parameter OUT_W, default 16: output word width in bits, including sign; legal range 4..32.
REQ-002 Parameter FRAC_W, default 0: fractional bits of the output, 0 <= FRAC_W < OUT_W-1.
REQ-003 Parameter FORMAT, default 0: 0 = sign-magnitude (bit OUT_W-1 is the sign), 1 = two's complement.
REQ-004 Parameter ROUND, default 0: 0 = truncate toward zero, 1 = round-to-nearest, ties-to-even.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 in_valid  in  1  double is valid this cycle.
REQ-008 in_ready  out  1  block accepts double this cycle.
REQ-009 double  in  64  IEEE-754 binary64 operand.
REQ-010 out_valid  out  1  fixed, sat and nan are valid.
REQ-011 out_ready  in  1  downstream accepts the result.
REQ-012 fixed  out  OUT_W  converted value, in units of 2^-FRAC_W.
REQ-013 sat  out  1  this result was clamped.
REQ-014 nan  out  1  this input was NaN.
REQ-015 sat_cnt  out  16  count of saturated results delivered; holds at 0xFFFF.

Function
REQ-016 Conversion is a 2-stage pipeline: stage 1 decodes the fields and aligns the mantissa; stage 2 rounds, saturates and formats.
REQ-017 Pipeline advance: enable = out_ready OR NOT out_valid; in_ready = enable.
REQ-018 With out_ready held high, the result for an input accepted in cycle N is presented with out_valid=1 in cycle N+2; throughput is 1 result per cycle.
REQ-019 While out_valid=1 and out_ready=0, fixed, sat, nan, out_valid and all stage-1 contents hold; no input is lost or duplicated and result order equals input order.
REQ-020 Let e = double[62:52] and k = e - 1023 + FRAC_W; the unrounded magnitude is 1.m * 2^k LSB, where m = double[51:0].
REQ-021 e = 0 (zero or subnormal) gives magnitude 0.
REQ-022 k < 0: truncate gives 0; round-to-nearest gives 1 only when k = -1 and m != 0; otherwise 0.
REQ-023 Round-to-nearest uses the guard bit plus the OR of all lower bits (sticky); ties round to the even magnitude.
REQ-024 If magnitude after rounding >= 2^(OUT_W-1), or k >= OUT_W-1, magnitude = 2^(OUT_W-1)-1 and sat = 1; this includes carry-out from rounding.
REQ-025 e = 2047 with m = 0 (infinity) saturates with the input sign; sat = 1, nan = 0.
REQ-026 e = 2047 with m != 0 (NaN) gives fixed = 0, nan = 1, sat = 0.
REQ-027 A zero magnitude always outputs all zeros, regardless of sign, so -0 and tiny negative values give +0.
REQ-028 FORMAT=0 output: {sign, magnitude[OUT_W-2:0]}. FORMAT=1 output: the two's complement of the magnitude when the sign is 1. Negative full scale is therefore -(2^(OUT_W-1)-1) in both formats.
REQ-029 sat_cnt increments by 1 on each cycle where out_valid AND out_ready AND sat; it holds at 0xFFFF.

Reset
REQ-030 While rst=1 at a clock edge: out_valid=0, fixed=0, sat=0, nan=0, sat_cnt=0, all stage-valid bits=0; in_ready=1 in the cycle after reset.
REQ-031 Reset asserted mid-operation discards all in-flight operands; no result for them is ever presented.

Structure
REQ-032 Package double_to_fixed_pkg holds: EXP_W=11, MAN_W=52, EXP_BIAS=1023, the FORMAT encodings and the ROUND encodings.
REQ-033 Stage 1 is the sub-module double_unpack: combinational decode of sign, exponent, mantissa, zero, inf and nan flags.

Verification (OUT_W=16, FRAC_W=0 unless stated)
REQ-034 0x3FF0000000000000 (1.0) -> fixed=0x0001, sat=0, nan=0; 0xC008000000000000 (-3.0) -> 0x8003 (FORMAT=0) or 0xFFFD (FORMAT=1); out_valid exactly 2 cycles after acceptance.
REQ-035 ROUND=1: 2.5 (0x4004000000000000) -> 0x0002; 3.5 (0x400C000000000000) -> 0x0004; 0.75 -> 0x0001. ROUND=0: 3.5 -> 0x0003.
REQ-036 65536.0 (0x40F0000000000000) -> 0x7FFF, sat=1, sat_cnt 0->1; -inf (0xFFF0000000000000) with FORMAT=1 -> 0x8001, sat=1; NaN 0x7FF8000000000000 -> 0x0000, nan=1.
REQ-037 FRAC_W=8: 1.5 -> 0x0180; 2^-9 (0x3F60000000000000) -> 0x0000 (ROUND=0).
REQ-038 Stream of 5 operands with out_ready held low for 3 cycles mid-stream -> in_ready drops, all 5 results delivered in order, none repeated.
REQ-039 rst pulsed while 2 operands are in flight -> out_valid=0 the next cycle, sat_cnt=0, and neither operand produces a result.

Source files
------------

// File: rtl/double_to_fixed_pkg.sv
// Shared constants for the binary64 to fixed-point converter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: binary64 field widths and bias, output format and rounding encodings,
// and the decoded-field struct produced by double_unpack.
package double_to_fixed_pkg;

  localparam int EXP_W    = 11;
  localparam int MAN_W    = 52;
  localparam int EXP_BIAS = 1023;

  // FORMAT parameter encodings
  localparam int FMT_SIGN_MAG  = 0;
  localparam int FMT_TWOS_COMP = 1;

  // ROUND parameter encodings
  localparam int RND_TRUNC   = 0;
  localparam int RND_NEAREST = 1;

  localparam logic [EXP_W-1:0] EXP_ALL_ONES = '1;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
    logic             zero;  // zero or subnormal: treated as magnitude 0
    logic             inf;
    logic             nan;
  } dbl_fields_t;

endpackage

// File: rtl/double_to_fixed_if.sv
// Handshake bundle between a binary64 producer, the converter and a fixed-point consumer.
// Latency: n/a (wiring only).
// Backpressure: carries in_valid/in_ready and out_valid/out_ready pairs.
// Ports: master = producer/consumer side, slave = converter side; sat_cnt is a
// status counter driven by the converter.
interface double_to_fixed_if #(
  parameter int OUT_W = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [63:0]      double;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] fixed;
  logic             sat;
  logic             nan;
  logic [15:0]      sat_cnt;

  modport master (
    output in_valid, double, out_ready,
    input  in_ready, out_valid, fixed, sat, nan, sat_cnt
  );

  modport slave (
    input  in_valid, double, out_ready,
    output in_ready, out_valid, fixed, sat, nan, sat_cnt
  );

endinterface

// File: rtl/double_unpack.sv
// Splits a binary64 word into sign/exponent/mantissa and classifies it.
// Latency: combinational.
// Backpressure: none (pure decode).
// Ports: double (64-bit operand) in; fields (dbl_fields_t) out.
module double_unpack
  import double_to_fixed_pkg::*;
(
  input  logic [63:0]  double,
  output dbl_fields_t  fields
);

  always_comb begin
    fields      = '0;
    fields.sign = double[EXP_W+MAN_W];
    fields.exp  = double[EXP_W+MAN_W-1:MAN_W];
    fields.man  = double[MAN_W-1:0];
    fields.zero = (fields.exp == '0);
    fields.inf  = (fields.exp == EXP_ALL_ONES) && (fields.man == '0);
    fields.nan  = (fields.exp == EXP_ALL_ONES) && (fields.man != '0);
  end

endmodule

// File: rtl/double_to_fixed.sv
// Converts IEEE-754 binary64 to OUT_W-bit fixed point with FRAC_W fraction bits.
// Latency: 2 cycles (decode/align, then round/saturate/format); 1 result per cycle.
// Backpressure: in_ready = out_ready | ~out_valid; a stalled output freezes both stages.
// Ports: clk, rst (synchronous, active high); bus (slave modport): in_valid/in_ready/double,
// out_valid/out_ready/fixed/sat/nan, and sat_cnt (saturated results delivered, sticks at 0xFFFF).
module double_to_fixed
  import double_to_fixed_pkg::*;
#(
  parameter int OUT_W  = 16,
  parameter int FRAC_W = 0,
  parameter int FORMAT = FMT_SIGN_MAG,
  parameter int ROUND  = RND_TRUNC
) (
  input logic              clk,
  input logic              rst,
  double_to_fixed_if.slave bus
);

  localparam int SIG_W = MAN_W + 1;
  localparam logic [OUT_W-1:0] MAG_FULL = {1'b0, {(OUT_W-1){1'b1}}};

  typedef struct packed {
    logic             vld;
    logic             sign;
    logic             nan;
    logic             ovf;     // |value| already >= full scale (incl. infinity)
    logic [OUT_W-1:0] mag;     // truncated magnitude in output LSBs
    logic             guard;   // first bit below the LSB
    logic             sticky;  // OR of every bit below the guard bit
  } stage1_t;

  dbl_fields_t f;
  stage1_t     s1_d, s1_q;

  logic                    en;
  logic signed [13:0]      k;
  logic [5:0]              sh;
  logic [SIG_W-1:0]        sig, sig_shr, sig_g, sticky_mask;

  logic                    rnd_up;
  logic [OUT_W-1:0]        mag_r, mag_f;
  logic [OUT_W-1:0]        fixed_d;
  logic                    sat_d, nan_d;

  logic                    out_valid_q;
  logic [OUT_W-1:0]        fixed_q;
  logic                    sat_q, nan_q;
  logic [15:0]             sat_cnt_q;

  logic                    unused_ok;

  assign en = bus.out_ready || !out_valid_q;

  double_unpack u_unpack (
    .double (bus.double),
    .fields (f)
  );

  // Stage 1: place the binary point. The value is sig * 2^(k-52), so the integer
  // part is sig >> (52-k); only 0 <= k <= OUT_W-2 needs the shifter, everything
  // else is either below one LSB or already out of range.
  always_comb begin
    sig         = {1'b1, f.man};
    k           = $signed({3'b000, f.exp}) - $signed(14'(EXP_BIAS)) + $signed(14'(FRAC_W));
    sh          = 6'($signed(14'(MAN_W)) - k);
    sig_shr     = sig >> sh;
    sig_g       = sig >> (sh - 6'd1);
    sticky_mask = (SIG_W'(1) << (sh - 6'd1)) - SIG_W'(1);

    s1_d        = '0;
    s1_d.vld    = bus.in_valid;
    s1_d.sign   = f.sign;
    s1_d.nan    = f.nan;

    if (f.nan || f.zero) begin
      // magnitude stays 0
    end else if (f.inf || (k >= $signed(14'(OUT_W - 1)))) begin
      s1_d.ovf = 1'b1;
    end else if (k >= 14'sd0) begin
      s1_d.mag    = sig_shr[OUT_W-1:0];
      s1_d.guard  = sig_g[0];
      s1_d.sticky = |(sig & sticky_mask);
    end else if (k == -14'sd1) begin
      // value in [0.5, 1): the hidden bit is the guard bit
      s1_d.guard  = 1'b1;
      s1_d.sticky = |f.man;
    end else begin
      // nonzero but below half an LSB: never rounds up
      s1_d.sticky = 1'b1;
    end
  end

  assign unused_ok = &{1'b0, sig_shr[SIG_W-1:OUT_W], sig_g[SIG_W-1:1]};

  // Stage 2: round, clamp, format.
  always_comb begin
    rnd_up  = (ROUND == RND_NEAREST) && s1_q.guard && (s1_q.sticky || s1_q.mag[0]);
    mag_r   = s1_q.mag + OUT_W'(rnd_up);
    // rounding carry into the sign position is an overflow too
    sat_d   = !s1_q.nan && (s1_q.ovf || mag_r[OUT_W-1]);
    nan_d   = s1_q.nan;
    mag_f   = sat_d ? MAG_FULL : mag_r;
    fixed_d = '0;
    if (s1_q.nan || (mag_f == '0)) begin
      fixed_d = '0;  // -0 and tiny negatives come out as +0
    end else if (FORMAT == FMT_SIGN_MAG) begin
      fixed_d = {s1_q.sign, mag_f[OUT_W-2:0]};
    end else begin
      fixed_d = s1_q.sign ? (-mag_f) : mag_f;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      fixed_q     <= '0;
      sat_q       <= 1'b0;
      nan_q       <= 1'b0;
      sat_cnt_q   <= '0;
    end else begin
      if (en) begin
        s1_q        <= s1_d;
        out_valid_q <= s1_q.vld;
        if (s1_q.vld) begin
          fixed_q <= fixed_d;
          sat_q   <= sat_d;
          nan_q   <= nan_d;
        end
      end
      if (out_valid_q && bus.out_ready && sat_q && (sat_cnt_q != 16'hFFFF)) begin
        sat_cnt_q <= sat_cnt_q + 16'd1;
      end
    end
  end

  assign bus.in_ready  = en;
  assign bus.out_valid = out_valid_q;
  assign bus.fixed     = fixed_q;
  assign bus.sat       = sat_q;
  assign bus.nan       = nan_q;
  assign bus.sat_cnt   = sat_cnt_q;

endmodule
